// File: rtl/mips_data_responder_if.sv
// CPU data-bus and TX byte-stream signals shared by the responder and its bus master.
// The master drives address/strobes/write data and tx_ready; the slave returns read data, TX head and err.
interface mips_data_responder_if;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        err;

  modport master (
    output data_address, data_write, data_read, data_writedata, tx_ready,
    input  data_readdata, tx_valid, tx_data, err
  );

  modport slave (
    input  data_address, data_write, data_read, data_writedata, tx_ready,
    output data_readdata, tx_valid, tx_data, err
  );
endinterface

// File: rtl/mips_data_responder.sv
// MIPS data-side responder: word RAM, cycle counter and a TX byte FIFO behind memory-mapped registers.
// Reads are combinational, writes commit at the edge; TX pops on tx_valid&tx_ready, full pushes drop unless popped.
module mips_data_responder #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_enable,
  mips_data_responder_if.slave   bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [29:0] CYCLE_WA  = 30'h3FFF_C000;
  localparam logic [29:0] TX_WA     = 30'h3FFF_C001;
  localparam logic [29:0] STATUS_WA = 30'h3FFF_C002;

  logic [31:0] ram [RAM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic          err_q;
  logic [31:0]   cycle_count;

  logic [29:0] word_addr;
  logic        hit_ram, hit_cycle, hit_tx, hit_status, unmapped;
  logic        wr_en, fifo_empty, fifo_full, pop, push_req, push;
  logic [31:0] read_word;
  logic        unused_addr_bits;

  assign word_addr        = bus.data_address[31:2];
  assign unused_addr_bits = ^bus.data_address[1:0];
  assign hit_ram    = ({2'b00, word_addr} < 32'(RAM_WORDS));
  assign hit_cycle  = (word_addr == CYCLE_WA);
  assign hit_tx     = (word_addr == TX_WA);
  assign hit_status = (word_addr == STATUS_WA);
  assign unmapped   = !(hit_ram || hit_cycle || hit_tx || hit_status);

  assign wr_en      = bus.data_write && clk_enable;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && bus.tx_ready;
  assign push_req   = wr_en && hit_tx;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push       = push_req && (!fifo_full || pop);

  always_comb begin
    read_word = '0;
    if (hit_ram)
      read_word = ram[word_addr[AW-1:0]];
    else if (hit_cycle)
      read_word = cycle_count;
    else if (hit_tx)
      read_word = {{(31-PW){1'b0}}, count};
    else if (hit_status)
      read_word = {29'b0, overflow, fifo_full, fifo_empty};
    bus.data_readdata = bus.data_read ? read_word : '0;
  end

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
  assign bus.err      = err_q;

  // Storage arrays are never reset; only the pointers and flags are.
  always_ff @(posedge clk) begin
    if (!reset && wr_en && hit_ram)
      ram[word_addr[AW-1:0]] <= bus.data_writedata;
    if (!reset && push)
      fifo_mem[wr_ptr] <= bus.data_writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (clk_enable)
        cycle_count <= (bus.data_write && hit_cycle) ? 32'h0 : cycle_count + 32'd1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && fifo_full && !pop)
        overflow <= 1'b1;
      else if (wr_en && hit_status && bus.data_writedata[2])
        overflow <= 1'b0;
      if (unmapped && (bus.data_read || wr_en))
        err_q <= 1'b1;
    end
  end
endmodule
